serializer: RTL
===============

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 The block SHALL have exactly one parameter: GAP_CYCLES, default 1, giving the number of idle cycles (write_out low) after each bit strobe; legal range 0..15.
REQ-002 The ports SHALL be as follows:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- byte_in  input  8  parallel byte to transmit.
- valid_in  input  1  byte_in is valid this cycle.
- ready_out  output  1  block can accept a byte this cycle.
- status_in  input  1  downstream deserializer ready for a new byte.
- data_out  output  1  serial bit, LSB first.
- write_out  output  1  one-cycle strobe; data_out is valid while it is high.
- busy_out  output  1  a byte is held and not yet fully sent.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, on ports named clock and reset.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, WAIT_READY, SEND and GAP.
REQ-005 ready_out SHALL be 1 only in IDLE; it SHALL be decoded combinationally from the state.
REQ-006 A byte SHALL be accepted at a rising edge where valid_in and ready_out are both 1.
- byte_in is latched into an 8-bit shift register.
- The bit counter is cleared to 0.
- The FSM moves to WAIT_READY.
REQ-007 valid_in while ready_out is 0 SHALL be ignored; no byte is latched or queued.
REQ-008 In WAIT_READY, status_in SHALL be sampled each edge; when it is 1, the FSM enters SEND. While it is 0, the FSM stays in WAIT_READY indefinitely.
REQ-009 status_in SHALL be sampled only in WAIT_READY; a drop of status_in during SEND or GAP SHALL NOT pause transmission.
REQ-010 In SEND, the registered outputs SHALL be write_out=1 and data_out=shift[0] for exactly one cycle.
- At the next edge, the shift register shifts right by one and the bit counter increments (3-bit, 0..7).
REQ-011 Transitions out of SEND SHALL be:
- to GAP if GAP_CYCLES>0;
- else to SEND if bit counter<7;
- else to IDLE.
REQ-012 GAP SHALL last exactly GAP_CYCLES cycles, counted by a 4-bit gap counter. At its end, the FSM enters SEND if fewer than 8 bits have been sent, else IDLE.
REQ-013 The last bit SHALL also be followed by its GAP, so the bit period is uniform at 1+GAP_CYCLES cycles.
REQ-014 Timing, for acceptance at edge N with status_in already 1:
- bit k strobe is high in the cycle after edge N+1+k*(1+GAP_CYCLES);
- ready_out returns to 1 after edge N+1+8*(1+GAP_CYCLES).
REQ-015 Outside SEND, write_out SHALL be 0 and data_out SHALL be 0.
REQ-016 busy_out SHALL be 1 in WAIT_READY, SEND and GAP, and 0 in IDLE.
REQ-017 When valid_in is 1 in the first IDLE cycle after a byte completes, the next byte SHALL be accepted in that cycle (back-to-back operation, no extra bubble).

Reset
REQ-018 When reset is 1 at a rising edge, the block SHALL:
- set the FSM to IDLE;
- clear the shift register, bit counter and gap counter;
- drive write_out=0, data_out=0, busy_out=0 and ready_out=1 from the next cycle.
REQ-019 Reset asserted mid-byte SHALL abort the byte with no further strobes; the remaining bits are discarded.
REQ-020 reset SHALL override valid_in; no byte is accepted in a reset cycle.

Structure
REQ-021 The state enum (IDLE, WAIT_READY, SEND, GAP) and the constants BYTE_W=8 and BIT_CNT_W=3 SHALL live in the shared package serializer_pkg.
REQ-022 The block SHALL be a single module with no sub-module; the FSM, shift register and both counters are local.

Verification
REQ-023 With GAP_CYCLES=1 and status_in=1, sending byte 0x80 SHALL produce 8 strobes carrying data_out 0,0,0,0,0,0,0,1, spaced 2 cycles apart; ready_out SHALL return 17 cycles after acceptance.
REQ-024 With status_in held 0 for 20 cycles after acceptance of 0x81, there SHALL be no strobe and busy_out SHALL be 1; when status_in rises, the first strobe (bit=1) SHALL occur the cycle after the next edge.
REQ-025 With GAP_CYCLES=0, back-to-back bytes 0x55 then 0xAA SHALL produce 16 consecutive strobes with bits 1,0,1,0,1,0,1,0,0,1,0,1,0,1,0,1 and ready_out high for exactly one cycle between the two bytes.
REQ-026 Asserting reset after the 3rd strobe of 0xFF SHALL stop strobes immediately, and ready_out SHALL be 1 in the cycle after reset is released.
REQ-027 Pulsing valid_in with 0x33 during transmission of 0x0F SHALL be ignored: only the 8 bits of 0x0F appear, followed by IDLE.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and widths for the byte-to-bit serializer.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_READY,
    SEND,
    GAP
  } state_t;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;
  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/serializer.sv
// Shifts a parallel byte out LSB first, one strobed bit per SEND cycle,
// each followed by GAP_CYCLES idle cycles, once the downstream side is ready.
module serializer
  import serializer_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              status_in,
  output logic              data_out,
  output logic              write_out,
  output logic              busy_out
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BYTE_W - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

  state_t                 state;
  state_t                 next_state;
  logic [BYTE_W-1:0]      shift;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (valid_in) begin
            shift   <= byte_in;
            bit_cnt <= '0;
          end
        end
        SEND: begin
          shift   <= {1'b0, shift[BYTE_W-1:1]};
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          gap_cnt <= '0;
        end
        GAP: begin
          gap_cnt <= gap_cnt + GAP_CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Inside GAP the bit counter has already advanced; it wraps to 0 only
  // after the eighth bit, which marks the byte as finished.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (valid_in) next_state = WAIT_READY;
      end
      WAIT_READY: begin
        if (status_in) next_state = SEND;
      end
      SEND: begin
        if (GAP_CYCLES > 0)          next_state = GAP;
        else if (bit_cnt != BIT_LAST) next_state = SEND;
        else                          next_state = IDLE;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) next_state = (bit_cnt == '0) ? IDLE : SEND;
      end
      default: next_state = IDLE;
    endcase
  end

  assign ready_out = (state == IDLE);
  assign busy_out  = (state != IDLE);
  assign write_out = (state == SEND);
  assign data_out  = (state == SEND) ? shift[0] : 1'b0;

endmodule
